// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-aware AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/axis_arb_select.sv
// Combinational request selector: rotating priority encoder built as a
// double-width masked search, or plain lowest-index-wins in fixed mode.
module axis_arb_select
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PRIO      = PRIO_RR,
  parameter int IDXW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDXW-1:0]      last_grant,
  output logic                 any_req,
  output logic [IDXW-1:0]      winner
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [2*NUM_PORTS-1:0] masked;
  logic                   found;
  int                     start;

  assign any_req = |req;

  // Upper copy of req lets the search wrap past port N-1 without modulo logic.
  always_comb begin
    start  = (PRIO == PRIO_FIXED) ? 0 : int'(last_grant) + 1;
    dbl    = {req, req};
    masked = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      masked[i] = dbl[i] && (i >= start);
    end
    for (int i = 0; i < 2*NUM_PORTS; i++) begin
      if (masked[i] && !found) begin
        winner = IDXW'(i % NUM_PORTS);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// N:1 AXI-Stream arbiter that holds each grant for a whole packet.
// Data path is purely combinational; only grant state is registered.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int WIDTH     = 64,
  parameter  int NUM_PORTS = 4,
  parameter  int PRIO      = PRIO_RR,
  localparam int IDXW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS*WIDTH-1:0] i_tdata,
  input  logic [NUM_PORTS-1:0]       i_tvalid,
  input  logic [NUM_PORTS-1:0]       i_tlast,
  output logic [NUM_PORTS-1:0]       i_tready,
  output logic [WIDTH-1:0]           o_tdata,
  output logic                       o_tvalid,
  output logic                       o_tlast,
  input  logic                       o_tready,
  output logic                       grant_valid,
  output logic [IDXW-1:0]            grant_idx
);

  arb_state_t      state, state_nxt;
  logic [IDXW-1:0] last_grant;
  logic            any_req;
  logic [IDXW-1:0] winner;

  axis_arb_select #(
    .NUM_PORTS (NUM_PORTS),
    .PRIO      (PRIO),
    .IDXW      (IDXW)
  ) u_sel (
    .req        (i_tvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Reset value of last_grant makes port 0 the first round-robin winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      last_grant <= IDXW'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        grant_idx  <= winner;
        last_grant <= winner;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_PKT;
      ST_PKT:  if (o_tvalid && o_tready && o_tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tdata  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    i_tready = '0;
    if (state == ST_PKT) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_idx == IDXW'(p)) begin
          o_tdata     = i_tdata[p*WIDTH +: WIDTH];
          o_tvalid    = i_tvalid[p];
          o_tlast     = i_tlast[p];
          i_tready[p] = o_tready;
        end
      end
    end
  end

  assign grant_valid = (state == ST_PKT);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomized bench for axis_pkt_arbiter: one round-robin and one fixed-priority
// instance, each checked every cycle against a packet-level reference model.
module tb_axis_pkt_arbiter;
  localparam int W  = 64;
  localparam int NP = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NP*W-1:0] i_tdata [2];
  logic [NP-1:0]   i_tvalid[2];
  logic [NP-1:0]   i_tlast [2];
  logic [NP-1:0]   i_tready[2];
  logic [W-1:0]    o_tdata [2];
  logic            o_tvalid[2];
  logic            o_tlast [2];
  logic            o_tready[2];
  logic            grant_valid[2];
  logic [IW-1:0]   grant_idx[2];

  axis_pkt_arbiter #(.WIDTH(W), .NUM_PORTS(NP), .PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata[0]), .i_tvalid(i_tvalid[0]), .i_tlast(i_tlast[0]), .i_tready(i_tready[0]),
    .o_tdata(o_tdata[0]), .o_tvalid(o_tvalid[0]), .o_tlast(o_tlast[0]), .o_tready(o_tready[0]),
    .grant_valid(grant_valid[0]), .grant_idx(grant_idx[0]));

  axis_pkt_arbiter #(.WIDTH(W), .NUM_PORTS(NP), .PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .i_tdata(i_tdata[1]), .i_tvalid(i_tvalid[1]), .i_tlast(i_tlast[1]), .i_tready(i_tready[1]),
    .o_tdata(o_tdata[1]), .o_tvalid(o_tvalid[1]), .o_tlast(o_tlast[1]), .o_tready(o_tready[1]),
    .grant_valid(grant_valid[1]), .grant_idx(grant_idx[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    bit           last;
  } beat_t;

  // Source queues and observed output beats, indexed d*NP+p.
  beat_t        src_q [2*NP][$];
  logic [W-1:0] seen_q[2*NP][$];

  // Reference model: granted port (-1 = idle), last round-robin winner, held index.
  int mg[2], mlast[2], midx[2];
  int xfer_cnt[2][NP];
  int order[2][$];
  int gaps[2][$];
  int gap_run[2];
  bit gv_prev[2];
  int rdy3_seen[2];
  int drop[2];
  bit rdy_rand, drop_arm;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Spec selection rule: first requesting port from the search start, wrapping.
  function automatic int pick(int d);
    int start;
    start = (d == 1) ? 0 : (mlast[d] + 1) % NP;
    for (int k = 0; k < NP; k++)
      if (i_tvalid[d][(start + k) % NP]) return (start + k) % NP;
    return -1;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        int q;
        q = d*NP + p;
        if (src_q[q].size() > 0) begin
          i_tvalid[d][p]       = !(p == 0 && drop[d] > 0);
          i_tdata[d][p*W +: W] = src_q[q][0].data;
          i_tlast[d][p]        = src_q[q][0].last;
        end else begin
          i_tvalid[d][p]       = 1'b0;
          i_tdata[d][p*W +: W] = {$urandom, $urandom};
          i_tlast[d][p]        = 1'($urandom % 2);
        end
      end
      o_tready[d] = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end
  endtask

  task automatic step();
    int nmg[2], nlast[2], nidx[2], xf[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("gv%0d", d), grant_valid[d], mg[d] >= 0);
      chk($sformatf("gidx%0d", d), grant_idx[d], midx[d]);
      if (mg[d] < 0) begin
        chk($sformatf("idle_ov%0d", d), o_tvalid[d], 0);
        chk($sformatf("idle_od%0d", d), o_tdata[d], 0);
        chk($sformatf("idle_ol%0d", d), o_tlast[d], 0);
        chk($sformatf("idle_rdy%0d", d), i_tready[d], 0);
      end else begin
        int g;
        g = mg[d];
        chk($sformatf("ov%0d", d), o_tvalid[d], i_tvalid[d][g]);
        chk($sformatf("od%0d", d), o_tdata[d], i_tdata[d][g*W +: W]);
        chk($sformatf("ol%0d", d), o_tlast[d], i_tlast[d][g]);
        chk($sformatf("rdy%0d", d), i_tready[d], o_tready[d] ? (4'b1 << g) : 4'b0);
      end
      if (grant_valid[d] && !gv_prev[d]) begin
        order[d].push_back(int'(grant_idx[d]));
        gaps[d].push_back(gap_run[d]);
      end
      gap_run[d] = grant_valid[d] ? 0 : gap_run[d] + 1;
      gv_prev[d] = grant_valid[d];
      if (i_tready[d][3] && src_q[d*NP+1].size() > 0) rdy3_seen[d]++;

      nmg[d] = mg[d]; nlast[d] = mlast[d]; nidx[d] = midx[d]; xf[d] = -1;
      if (reset) begin
        nmg[d] = -1; nlast[d] = NP - 1; nidx[d] = 0;
      end else if (mg[d] < 0) begin
        int w;
        w = pick(d);
        if (w >= 0) begin nmg[d] = w; nidx[d] = w; nlast[d] = w; end
      end else if (i_tvalid[d][mg[d]] && o_tready[d]) begin
        xf[d] = mg[d];
        seen_q[d*NP + mg[d]].push_back(o_tdata[d]);
        if (i_tlast[d][mg[d]]) nmg[d] = -1;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mg[d] = nmg[d]; mlast[d] = nlast[d]; midx[d] = nidx[d];
      if (drop[d] > 0) drop[d]--;
      if (xf[d] >= 0) begin
        void'(src_q[d*NP + xf[d]].pop_front());
        xfer_cnt[d][xf[d]]++;
        if (drop_arm && xf[d] == 0 && xfer_cnt[d][0] == 3) drop[d] = 5;
      end
    end
    drive();
  endtask

  function automatic bit busy();
    for (int q = 0; q < 2*NP; q++) if (src_q[q].size() > 0) return 1'b1;
    return (mg[0] >= 0) || (mg[1] >= 0);
  endfunction

  task automatic run(input string tag, input int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin step(); n++; end
    chk({tag, "_timeout"}, busy(), 0);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      order[d].delete(); gaps[d].delete();
      rdy3_seen[d] = 0;
      for (int p = 0; p < NP; p++) begin
        xfer_cnt[d][p] = 0;
        seen_q[d*NP + p].delete();
      end
    end
  endtask

  task automatic flush();
    for (int q = 0; q < 2*NP; q++) src_q[q].delete();
  endtask

  task automatic add_pkt(input int d, input int p, input int len, input logic [W-1:0] base);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = base + W'(b);
      bt.last = (b == len - 1);
      src_q[d*NP + p].push_back(bt);
    end
  endtask

  task automatic do_reset();
    flush();
    reset = 1'b1;
    drive();
    repeat (2) step();
    reset = 1'b0;
    drive();
  endtask

  initial begin
    reset = 1'b1;
    rdy_rand = 1'b0; drop_arm = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mg[d] = -1; mlast[d] = NP - 1; midx[d] = 0;
      gap_run[d] = 0; gv_prev[d] = 1'b0; drop[d] = 0;
    end
    clear_logs();
    drive();
    @(posedge clk);
    #1;

    // Reset then idle, then one 4-beat ramp on port 2.
    do_reset();
    repeat (10) step();
    clear_logs();
    for (int d = 0; d < 2; d++) add_pkt(d, 2, 4, 64'h10);
    drive();
    run("ramp", 50);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ramp_ngr%0d", d), order[d].size(), 1);
      if (order[d].size() > 0) chk($sformatf("ramp_gidx%0d", d), order[d][0], 2);
      chk($sformatf("ramp_beats%0d", d), seen_q[d*NP+2].size(), 4);
      for (int b = 0; b < seen_q[d*NP+2].size(); b++)
        chk($sformatf("ramp_data%0d", d), seen_q[d*NP+2][b], 64'h10 + b);
    end

    // All ports stream 3-beat packets continuously.
    do_reset();
    clear_logs();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < 2; k++) add_pkt(d, p, 3, 64'h1000 * (p + 1) + 64'h100 * k);
    drive();
    run("rr", 200);
    chk("rr_ngr", order[0].size(), 8);
    for (int i = 0; i < order[0].size(); i++) chk("rr_order", order[0][i], i % NP);
    for (int i = 1; i < gaps[0].size(); i++) chk("rr_gap", gaps[0][i], 1);
    for (int i = 0; i < order[1].size(); i++) chk("fp_all_order", order[1][i], i / 2);

    // Ports 1 and 3 both request continuously.
    clear_logs();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        add_pkt(d, 1, 2, 64'h2000 + 64'h10 * k);
        add_pkt(d, 3, 2, 64'h3000 + 64'h10 * k);
      end
    drive();
    run("prio", 200);
    chk("fp_ngr", order[1].size(), 8);
    for (int i = 0; i < 4 && i < order[1].size(); i++) chk("fp_p1_wins", order[1][i], 1);
    chk("fp_rdy3", rdy3_seen[1], 0);
    for (int i = 0; i < order[0].size(); i++) chk("rr_alt", order[0][i], (i % 2) ? 3 : 1);

    // Random backpressure, port 0 drops valid for 5 cycles mid-packet.
    clear_logs();
    rdy_rand = 1'b1; drop_arm = 1'b1;
    for (int d = 0; d < 2; d++) begin
      add_pkt(d, 0, 12, 64'h100);
      for (int p = 1; p < NP; p++) add_pkt(d, p, 1 + $urandom_range(0, 3), 64'h5000 * p);
    end
    drive();
    run("bp", 600);
    rdy_rand = 1'b0; drop_arm = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_beats%0d", d), seen_q[d*NP].size(), 12);
      for (int b = 0; b < seen_q[d*NP].size(); b++)
        chk($sformatf("bp_data%0d", d), seen_q[d*NP][b], 64'h100 + b);
    end

    // Reset asserted while beat 3 of an 8-beat packet is presented.
    do_reset();
    clear_logs();
    for (int d = 0; d < 2; d++) add_pkt(d, 0, 8, 64'h700);
    drive();
    for (int n = 0; n < 40 && !(xfer_cnt[0][0] == 2 && xfer_cnt[1][0] == 2); n++) step();
    chk("mid_reach", xfer_cnt[0][0] + xfer_cnt[1][0], 4);
    reset = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid_gv%0d", d), grant_valid[d], 0);
      chk($sformatf("mid_rdy%0d", d), i_tready[d], 0);
    end
    reset = 1'b0;
    flush();
    clear_logs();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++) add_pkt(d, p, 2, 64'h9000 + 64'h100 * p);
    drive();
    run("post_rst", 100);
    for (int d = 0; d < 2; d++)
      if (order[d].size() > 0) chk($sformatf("post_rst_first%0d", d), order[d][0], 0);
      else chk($sformatf("post_rst_none%0d", d), 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
